// File: rtl/prom_arb.sv
// prom_arb: two-requester arbiter and read sequencer in front of the 512 x 32 boot PROM.
// Define PROM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module prom_arb #(
    parameter int WAIT_MAX = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [8:0]       m0_addr,
    output logic [31:0]      m0_data,
    output logic             m0_ack,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [8:0]       m1_addr,
    output logic [31:0]      m1_data,
    output logic             m1_ack,
    output logic             prom_stb,
    output logic             prom_we,
    output logic [8:0]       prom_addr,
    input  logic [31:0]      prom_data,
    input  logic             prom_ack,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    // IDLE arbitrate | RD wait for prom ack | WRJ reject write | DONE ack cycle, then bubble
    typedef enum logic [1:0] {IDLE, RD, WRJ, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_MAX - 1);

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             prom_stb_q, prom_stb_d;
    logic [8:0]       prom_addr_q, prom_addr_d;
    logic [31:0]      m0_data_q, m0_data_d;
    logic [31:0]      m1_data_q, m1_data_d;
    logic             m0_ack_q, m0_ack_d;
    logic             m1_ack_q, m1_ack_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             req_any;
    logic             win;
    logic             win_we;
    logic [8:0]       win_addr;
    logic             rd_done;
    logic             rd_tmo;
    logic             fin;
    logic [31:0]      fin_data;

`ifdef PROM_ARB_RR_EN
    logic last_q, last_d;
    assign win = (m0_stb && m1_stb) ? ~last_q : ~m0_stb;
`else
    assign win = ~m0_stb;
`endif

    assign req_any  = m0_stb | m1_stb;
    assign win_we   = win ? m1_we : m0_we;
    assign win_addr = win ? m1_addr : m0_addr;

    // The ack level seen in the first RD cycle is left over from the previous access.
    assign rd_done  = (state_q == RD) && (cnt_q != 4'd0) && prom_ack;
    assign rd_tmo   = (state_q == RD) && !rd_done && (cnt_q == CNT_LAST);
    assign fin      = rd_done | rd_tmo | (state_q == WRJ);
    assign fin_data = rd_done ? prom_data : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            cnt_q       <= 4'd0;
            prom_stb_q  <= 1'b0;
            prom_addr_q <= 9'd0;
            m0_data_q   <= 32'h0;
            m1_data_q   <= 32'h0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
`ifdef PROM_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            prom_stb_q  <= prom_stb_d;
            prom_addr_q <= prom_addr_d;
            m0_data_q   <= m0_data_d;
            m1_data_q   <= m1_data_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
`ifdef PROM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = win_we ? WRJ : RD;
            RD:      if (rd_done || rd_tmo) state_d = DONE;
            WRJ:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        prom_stb_d  = prom_stb_q;
        prom_addr_d = prom_addr_q;
        m0_data_d   = m0_data_q;
        m1_data_d   = m1_data_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
`ifdef PROM_ARB_RR_EN
        last_d      = last_q;
`endif
        if (state_q == IDLE && req_any) begin
            grant_d = win;
`ifdef PROM_ARB_RR_EN
            last_d  = win;
`endif
            if (!win_we) begin
                prom_stb_d  = 1'b1;
                prom_addr_d = win_addr;
                cnt_d       = 4'd0;
            end
        end
        if (state_q == RD) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (fin) begin
            prom_stb_d = 1'b0;
            err_d      = ~rd_done;
            if (grant_q) begin
                m1_ack_d  = 1'b1;
                m1_data_d = fin_data;
            end else begin
                m0_ack_d  = 1'b1;
                m0_data_d = fin_data;
            end
        end
        if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    assign m0_data   = m0_data_q;
    assign m0_ack    = m0_ack_q;
    assign m1_data   = m1_data_q;
    assign m1_ack    = m1_ack_q;
    assign prom_stb  = prom_stb_q;
    assign prom_we   = 1'b0;
    assign prom_addr = prom_addr_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: doc/prom_arb.md
Name: prom_arb

Overview:
- Two-requester arbiter and sequencer in front of the 512 x 32 boot PROM.
- Requester 0 is CPU instruction fetch; requester 1 is the debug/loader port.
- Each PROM read runs as one complete transaction. The PROM's toggling ack is converted into a clean one-cycle ack pulse per requester.
- Write attempts are rejected locally, because the PROM never acks writes. A watchdog keeps a requester from hanging.

Parameters:
- WAIT_MAX, 4: maximum PROM cycles per read before a forced error completion. Range 2..15.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset. Synchronous, active-low: asserted when 0, sampled on posedge clk.
- m0_stb  in  1  requester 0 strobe; held until m0_ack
- m0_we  in  1  requester 0 write enable
- m0_addr  in  9  requester 0 word address [10:2]
- m0_data  out  32  requester 0 read data; registered, valid while m0_ack=1
- m0_ack  out  1  requester 0 completion pulse
- m1_stb, m1_we, m1_addr, m1_data, m1_ack: same as requester 0, for requester 1
- prom_stb  out  1  PROM strobe
- prom_we  out  1  PROM write enable; always 0
- prom_addr  out  9  PROM word address
- prom_data  in  32  PROM read data
- prom_ack  in  1  PROM ack. Toggles on every cycle that has stb & ~we; stale between transactions.
- err  out  1  one-cycle pulse on a write reject or timeout
- err_cnt  out  ERR_W  saturating count of err pulses

Behaviour:
- Reset (rst=0 at posedge):
  - State becomes IDLE.
  - Outputs cleared: prom_stb=0, prom_addr=0, m0_ack=m1_ack=0, m0_data=m1_data=0, err=0, err_cnt=0, grant=0, last=1.
  - A transaction in flight is abandoned. No ack is issued for it.
- States: IDLE, RD, WRJ, DONE.
- IDLE:
  - Select a requester with stb=1 (see arbitration). Latch grant.
  - If the winner has we=1, go to WRJ.
  - Otherwise go to RD. Register prom_addr from the winner's addr, set prom_stb=1, clear the wait counter.
- RD:
  - The wait counter increments each cycle.
  - prom_ack is ignored in the first RD cycle (cnt=0), because its value is stale.
  - If prom_ack=1 with cnt>=1: clear prom_stb, load m<grant>_data from prom_data, set m<grant>_ack=1, go to DONE.
  - Normal completion is 1 or 2 cycles after the first, depending on the prior ack level.
  - If cnt reaches WAIT_MAX-1 without ack: clear prom_stb, m<grant>_data=0, pulse m<grant>_ack and err, go to DONE.
- WRJ:
  - Lasts one cycle. m<grant>_data=0, pulse m<grant>_ack and err, go to DONE.
  - prom_stb stays 0, so the PROM never sees a write.
- DONE:
  - Ack outputs return to 0. Go to IDLE.
  - The granted requester must drop stb at the edge where it sees ack. Arbitration resumes in IDLE one cycle later, so there is a one-cycle bubble between transactions.
- Acks are never asserted to both requesters in the same cycle. An ack is never asserted two cycles in a row.
- Arbitration (default): fixed priority. m0 wins whenever m0_stb=1.
- A requester that drops stb mid-transaction is a protocol violation. The transaction still completes and the ack is issued anyway.
- err_cnt increments on each err pulse and saturates at 2^ERR_W-1.

Optional Feature:
- Macro: PROM_ARB_RR_EN.
- Defined: round-robin arbitration. When both stb are high in IDLE, the requester not equal to `last` wins. `last` updates to the grant on every entry to RD or WRJ.
- Undefined: fixed priority to m0. The `last` register is not built.

Test Plan:
- Reset: hold rst=0 for 2 cycles with m0_stb=1 -> all outputs 0, no prom_stb; after release, the read starts in the first IDLE cycle.
- m0 read, addr 0x005, PROM word 5 = 0xDEADBEEF, prom_ack initially 0 -> prom_stb high 2 cycles; m0_ack pulses 1 cycle; m0_data=0xDEADBEEF; prom_addr=0x005.
- Back-to-back reads by m0 (prom_ack stale 1) -> second read takes 3 RD cycles, data correct, bubble of 1 IDLE cycle.
- m0_stb and m1_stb both held for 4 transactions -> default: m0 serviced every time; with PROM_ARB_RR_EN: grants alternate 0,1,0,1.
- m1 write (m1_we=1, addr 0x010) -> prom_stb never asserted; m1_ack pulses 2 cycles after the request; m1_data=0; err pulse; err_cnt=1.
- prom_ack tied 0, m0 read -> forced completion after WAIT_MAX=4 RD cycles; m0_ack and err pulse; err_cnt increments; repeat 300 times -> err_cnt saturates at 255.
